pio_irq_master: RTL and testbench
=================================

PIO_IRQ_MASTER -- requirements
Module: pio_irq_master

Interface
REQ-001 The block SHALL have parameter MASK_VALUE, default 32'h1, the value written to the PIO interrupt-mask register (offset 2) after reset.
REQ-002 The block SHALL have parameter CNT_W, default 16, the width of event_count.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port reset_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port enable, input, 1 bit, SHALL permit new service sequences when high.
REQ-006 Port irq, input, 1 bit, SHALL be the interrupt request from the PIO slave.
REQ-007 Port address, output, 2 bits, SHALL be the Avalon-MM word address to the PIO slave.
REQ-008 Port chipselect, output, 1 bit, SHALL mark an active access cycle.
REQ-009 Port write_n, output, 1 bit, SHALL be the active-low write strobe.
REQ-010 Port writedata, output, 32 bits, SHALL be the write data.
REQ-011 Port readdata, input, 32 bits, SHALL be the registered slave read data, valid one cycle after address is presented (fixed latency 1, no waitrequest).
REQ-012 Port busy, output, 1 bit, SHALL be high whenever the FSM is not in IDLE.
REQ-013 Port event_valid, output, 1 bit, SHALL pulse high for one cycle per completed service.
REQ-014 Port last_data, output, 1 bit, SHALL hold the pin level read in the latest service.
REQ-015 Port event_count, output, CNT_W bits, SHALL count completed services.
REQ-016 Port spurious_count, output, 8 bits, SHALL count services aborted because the captured edge bit was 0.

Function
REQ-017 The FSM SHALL have states INIT, IDLE, RD_CAP, CAP_WAIT, CLR, RD_DAT, DAT_WAIT, REPORT.
REQ-018 INIT (one cycle): chipselect=1, write_n=0, address=2, writedata=MASK_VALUE; next state IDLE.
REQ-019 IDLE: chipselect=1 is forbidden; go to RD_CAP when irq=1 and enable=1, else stay.
REQ-020 RD_CAP: chipselect=1, write_n=1, address=3; next CAP_WAIT.
REQ-021 CAP_WAIT: address held at 3, chipselect=0; sample readdata[0]; if 1 go to CLR, if 0 increment spurious_count (saturating at 255) and go to IDLE.
REQ-022 CLR: chipselect=1, write_n=0, address=3, writedata=0; next RD_DAT.
REQ-023 RD_DAT: chipselect=1, write_n=1, address=0; next DAT_WAIT.
REQ-024 DAT_WAIT: address held at 0, chipselect=0; latch readdata[0] into last_data; next REPORT.
REQ-025 REPORT: event_valid=1, event_count increments modulo 2^CNT_W (wraps to 0); next IDLE.
REQ-026 In every state other than INIT, CLR, RD_CAP, RD_DAT: chipselect=0, write_n=1, writedata=0.
REQ-027 Service latency SHALL be fixed: irq high in IDLE at cycle T -> event_valid high in cycle T+6.
REQ-028 enable falling mid-sequence SHALL NOT abort it; the sequence completes and the FSM rests in IDLE.
REQ-029 irq asserted while busy SHALL be ignored until IDLE; an edge arriving after CLR re-raises irq and is serviced on return to IDLE.
REQ-030 write_n=0 SHALL only occur together with chipselect=1.

Reset
REQ-031 On reset_n low, asynchronously: state=INIT, chipselect=0, write_n=1, address=0, writedata=0, busy=1, event_valid=0, last_data=0, event_count=0, spurious_count=0.
REQ-032 Reset asserted mid-sequence SHALL abandon it without completing the clear or the report; after release the FSM restarts at INIT.

Verification
REQ-033 Release reset -> exactly one write cycle, address=2, writedata=32'h1, then busy=0.
REQ-034 Slave model asserts irq, readdata at addr3=1, addr0=1 -> sequence read3, write3 with 0, read0; event_valid 6 cycles after irq; last_data=1; event_count=1.
REQ-035 irq high but addr3 reads 0 -> no write issued, spurious_count=1, event_count unchanged, return to IDLE.
REQ-036 enable=0 with irq high for 20 cycles -> no accesses; enable=1 -> service starts next cycle.
REQ-037 CNT_W=4, 16 services -> event_count wraps 15->0.
REQ-038 reset_n pulsed low during CAP_WAIT -> all outputs at reset values immediately, then INIT write repeated, no event_valid.

Source files
------------

// File: rtl/pio_irq_if.sv
// Avalon-MM word bus plus interrupt line between the IRQ master and a PIO slave.
`timescale 1ns/1ps
interface pio_irq_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/pio_irq_master.sv
// Services PIO edge interrupts: programs the mask once, then per IRQ reads and clears
// the edge-capture register, reads the pin level and reports a counted event.
`timescale 1ns/1ps
module pio_irq_master #(
  parameter logic [31:0] MASK_VALUE = 32'h1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  pio_irq_if.master        bus,
  output logic             busy,
  output logic             event_valid,
  output logic             last_data,
  output logic [CNT_W-1:0] event_count,
  output logic [7:0]       spurious_count
);
  localparam int unsigned AW = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 8;

  localparam logic [AW-1:0] ADDR_DATA = AW'(0);
  localparam logic [AW-1:0] ADDR_MASK = AW'(2);
  localparam logic [AW-1:0] ADDR_EDGE = AW'(3);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_RD_CAP, S_CAP_WAIT, S_CLR, S_RD_DAT, S_DAT_WAIT, S_REPORT
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [AW-1:0]  r_address, w_address_nxt;
  logic           r_cs, w_cs_nxt;
  logic           r_write_n, w_write_n_nxt;
  logic [DW-1:0]  r_wdata, w_wdata_nxt;
  logic           w_spur_inc;
  logic           r_busy, r_event_valid, r_last_data;
  logic [CNT_W-1:0] r_event_count;
  logic [SW-1:0]  r_spur_count;
  logic           w_unused_rd;

  assign w_unused_rd = ^bus.readdata[DW-1:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_INIT;
    else          r_state <= w_state_nxt;
  end

  // Next state, then bus outputs decoded from the state being entered so they are
  // registered yet aligned with the state. INIT holds until its write has been driven.
  always_comb begin
    w_state_nxt   = r_state;
    w_address_nxt = r_address;
    w_cs_nxt      = 1'b0;
    w_write_n_nxt = 1'b1;
    w_wdata_nxt   = '0;
    w_spur_inc    = 1'b0;

    case (r_state)
      S_INIT:     if (r_cs) w_state_nxt = S_IDLE;
      S_IDLE:     if (bus.irq && enable) w_state_nxt = S_RD_CAP;
      S_RD_CAP:   w_state_nxt = S_CAP_WAIT;
      S_CAP_WAIT: begin
        if (bus.readdata[0]) begin
          w_state_nxt = S_CLR;
        end else begin
          w_state_nxt = S_IDLE;
          w_spur_inc  = 1'b1;
        end
      end
      S_CLR:      w_state_nxt = S_RD_DAT;
      S_RD_DAT:   w_state_nxt = S_DAT_WAIT;
      S_DAT_WAIT: w_state_nxt = S_REPORT;
      S_REPORT:   w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_INIT;
    endcase

    case (w_state_nxt)
      S_INIT: begin
        w_cs_nxt      = 1'b1;
        w_write_n_nxt = 1'b0;
        w_address_nxt = ADDR_MASK;
        w_wdata_nxt   = MASK_VALUE;
      end
      S_RD_CAP: begin
        w_cs_nxt      = 1'b1;
        w_address_nxt = ADDR_EDGE;
      end
      S_CAP_WAIT: w_address_nxt = ADDR_EDGE;
      S_CLR: begin
        w_cs_nxt      = 1'b1;
        w_write_n_nxt = 1'b0;
        w_address_nxt = ADDR_EDGE;
      end
      S_RD_DAT: begin
        w_cs_nxt      = 1'b1;
        w_address_nxt = ADDR_DATA;
      end
      S_DAT_WAIT: w_address_nxt = ADDR_DATA;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_address     <= '0;
      r_cs          <= 1'b0;
      r_write_n     <= 1'b1;
      r_wdata       <= '0;
      r_busy        <= 1'b1;
      r_event_valid <= 1'b0;
      r_last_data   <= 1'b0;
      r_event_count <= '0;
      r_spur_count  <= '0;
    end else begin
      r_address     <= w_address_nxt;
      r_cs          <= w_cs_nxt;
      r_write_n     <= w_write_n_nxt;
      r_wdata       <= w_wdata_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_event_valid <= (w_state_nxt == S_REPORT);
      if (r_state == S_DAT_WAIT) r_last_data <= bus.readdata[0];
      if (w_state_nxt == S_REPORT) r_event_count <= r_event_count + CNT_W'(1);
      if (w_spur_inc && (r_spur_count != {SW{1'b1}})) r_spur_count <= r_spur_count + SW'(1);
    end
  end

  assign bus.address    = r_address;
  assign bus.chipselect = r_cs;
  assign bus.write_n    = r_write_n;
  assign bus.writedata  = r_wdata;
  assign busy           = r_busy;
  assign event_valid    = r_event_valid;
  assign last_data      = r_last_data;
  assign event_count    = r_event_count;
  assign spurious_count = r_spur_count;
endmodule

// File: tb/tb_pio_irq_master.sv
// Randomized service sequences against a PIO slave model; expectations come from
// event/spurious tallies and the expected access list of each service.
`timescale 1ns/1ps
module tb_pio_irq_master;
  localparam int unsigned CNT_W = 4;
  localparam logic [31:0] MASK  = 32'h1;

  typedef struct packed {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
  } acc_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  logic             busy, event_valid, last_data;
  logic [CNT_W-1:0] event_count;
  logic [7:0]       spurious_count;

  pio_irq_if bus ();

  pio_irq_master #(.MASK_VALUE(MASK), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .bus            (bus),
    .busy           (busy),
    .event_valid    (event_valid),
    .last_data      (last_data),
    .event_count    (event_count),
    .spurious_count (spurious_count)
  );

  always #5 clk = ~clk;

  // PIO slave: edge-capture bit, mask register, pin level, registered read data
  logic        s_cap;
  logic [31:0] s_mask;
  logic        s_pin;
  logic        s_irq_force;
  int unsigned edge_cnt, edge_seen;

  assign bus.irq = (s_cap & s_mask[0]) | s_irq_force;

  always @(posedge clk or negedge reset_n) begin : slave
    logic [31:0] rnd;
    rnd = $urandom;
    if (!reset_n) begin
      s_cap        <= 1'b0;
      s_mask       <= '0;
      bus.readdata <= '0;
      edge_seen    <= edge_cnt;
    end else begin
      if (bus.chipselect && !bus.write_n) begin
        if (bus.address == 2'd2) s_mask <= bus.writedata;
        if (bus.address == 2'd3) s_cap  <= 1'b0;
      end else if (edge_cnt != edge_seen) begin
        s_cap <= 1'b1;
      end
      edge_seen <= edge_cnt;
      if (bus.chipselect && bus.write_n) begin
        case (bus.address)
          2'd0:    rnd[0] = s_pin;
          2'd2:    rnd    = s_mask;
          2'd3:    rnd[0] = s_cap;
          default: rnd    = '0;
        endcase
      end
      bus.readdata <= rnd;
    end
  end

  acc_t        log_q[$];
  int unsigned viol = 0;

  always @(negedge clk) begin
    if (bus.chipselect)
      log_q.push_back(acc_t'({~bus.write_n, bus.address, bus.write_n ? 32'h0 : bus.writedata}));
    if (!bus.chipselect && (!bus.write_n || bus.writedata != 32'h0)) viol++;
  end

  int n_vec = 0;
  int n_err = 0;
  int m_evt = 0;
  int m_spur = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic acc_t mk(input logic wr, input logic [1:0] a, input logic [31:0] d);
    return '{wr: wr, addr: a, data: d};
  endfunction

  function automatic logic [63:0] exp_cnt();
    return 64'(m_evt % (1 << CNT_W));
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    check("idle_reached", 64'(busy), 64'(0));
  endtask

  task automatic check_reset_vals();
    check("rst_cs",    64'(bus.chipselect), 64'(0));
    check("rst_wr_n",  64'(bus.write_n),    64'(1));
    check("rst_addr",  64'(bus.address),    64'(0));
    check("rst_wdata", 64'(bus.writedata),  64'(0));
    check("rst_busy",  64'(busy),           64'(1));
    check("rst_ev",    64'(event_valid),    64'(0));
    check("rst_last",  64'(last_data),      64'(0));
    check("rst_evcnt", 64'(event_count),    64'(0));
    check("rst_spur",  64'(spurious_count), 64'(0));
  endtask

  task automatic check_init_write();
    check("init_len", 64'(log_q.size()), 64'(1));
    check("init_acc", 64'(log_q[0]),     64'(mk(1'b1, 2'd2, MASK)));
  endtask

  // One interrupt: a real edge (full service) or a forced irq with no captured edge
  task automatic service(input bit spur, input bit pin, input bit drop_en);
    bit early;
    wait_idle();
    log_q.delete();
    s_pin = pin;
    if (spur) s_irq_force = 1'b1;
    else begin
      edge_cnt++;
      tick();
    end
    early = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin
        s_irq_force = 1'b0;
        check("busy_run", 64'(busy), 64'(1));
      end
      if (k == 2 && drop_en) enable = 1'b0;
      if (spur || k != 6) begin
        if (event_valid) early = 1'b1;
      end else begin
        m_evt++;
        check("ev_at_t6",  64'(event_valid), 64'(1));
        check("last_data", 64'(last_data),   64'(pin));
        check("ev_count",  64'(event_count), exp_cnt());
      end
    end
    enable = 1'b1;
    if (spur && m_spur < 255) m_spur++;
    check("ev_stray",   64'(early),          64'(0));
    check("spur_count", 64'(spurious_count), 64'(m_spur));
    check("ev_count_end", 64'(event_count),  exp_cnt());
    if (spur) begin
      check("spur_log_len", 64'(log_q.size()), 64'(1));
      check("spur_acc0",    64'(log_q[0]),     64'(mk(1'b0, 2'd3, 32'h0)));
    end else begin
      check("svc_log_len", 64'(log_q.size()), 64'(3));
      check("svc_rd_cap",  64'(log_q[0]),     64'(mk(1'b0, 2'd3, 32'h0)));
      check("svc_clr",     64'(log_q[1]),     64'(mk(1'b1, 2'd3, 32'h0)));
      check("svc_rd_dat",  64'(log_q[2]),     64'(mk(1'b0, 2'd0, 32'h0)));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit early;
    reset_n     = 1'b0;
    enable      = 1'b1;
    s_pin       = 1'b0;
    s_irq_force = 1'b0;
    edge_cnt    = 0;
    tick();
    tick();
    check_reset_vals();

    log_q.delete();
    reset_n = 1'b1;
    repeat (4) tick();
    check_init_write();
    check("init_busy", 64'(busy), 64'(0));

    service(1'b0, 1'b1, 1'b0);
    service(1'b1, 1'b0, 1'b0);
    service(1'b0, 1'b0, 1'b1);

    // enable low holds off a pending interrupt; raising it starts service next cycle
    wait_idle();
    log_q.delete();
    enable = 1'b0;
    s_pin  = 1'b1;
    edge_cnt++;
    repeat (20) tick();
    check("en_no_acc", 64'(log_q.size()), 64'(0));
    check("en_idle",   64'(busy),         64'(0));
    enable = 1'b1;
    tick();
    check("en_start", 64'({bus.chipselect, bus.write_n, bus.address}), 64'({1'b1, 1'b1, 2'd3}));
    repeat (5) tick();
    m_evt++;
    check("en_ev",    64'(event_valid), 64'(1));
    check("en_last",  64'(last_data),   64'(1));
    check("en_count", 64'(event_count), exp_cnt());

    // a new edge after the clear re-raises irq and is serviced back to back
    wait_idle();
    log_q.delete();
    s_pin = 1'b0;
    edge_cnt++;
    tick();
    early = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 4) edge_cnt++;
      if (k == 6 || k == 13) begin
        m_evt++;
        check("rr_ev",    64'(event_valid), 64'(1));
        check("rr_count", 64'(event_count), exp_cnt());
      end else if (event_valid) begin
        early = 1'b1;
      end
    end
    check("rr_stray",   64'(early),        64'(0));
    check("rr_log_len", 64'(log_q.size()), 64'(6));

    for (int i = 0; i < 40; i++)
      service(($urandom % 4) == 0, 1'($urandom), ($urandom % 3) == 0);

    for (int i = 0; i < 260; i++)
      service(1'b1, 1'($urandom), 1'b0);
    check("spur_saturated", 64'(spurious_count), 64'(255));

    // reset while waiting on the capture read abandons the service
    wait_idle();
    edge_cnt++;
    tick();
    tick();
    tick();
    check("capwait_bus", 64'({bus.chipselect, bus.address}), 64'({1'b0, 2'd3}));
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    tick();
    log_q.delete();
    reset_n = 1'b1;
    early = 1'b0;
    repeat (10) begin
      tick();
      if (event_valid) early = 1'b1;
    end
    check("rst_no_ev", 64'(early), 64'(0));
    check_init_write();
    check("rst_count", 64'(event_count), 64'(0));

    check("bus_rules", 64'(viol), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
